// File: rtl/elevator_call_dispatcher_if.sv
// Bundle between the call dispatcher and the elevator controller.
// Request/status handshake: a request output (close_req, open_req, up_req,
// down_req, stop) stays high for as long as the dispatcher waits in the state
// that issues it. The request is confirmed only by the matching controller
// status level: open==0 for close_req, moving==0 for stop, open==1 for
// open_req. Travel requests are confirmed per floor by floor_tick. No request
// is withdrawn before its confirmation, except when error forces FAULT.
interface elevator_call_dispatcher_if #(
   parameter int FLOORS = 8,
   parameter int FW     = 3
);
   logic [FLOORS-1:0] call_btn;
   logic              floor_tick;
   logic              open;
   logic              moving;
   logic              error;
   logic              close_req;
   logic              open_req;
   logic              up_req;
   logic              down_req;
   logic              stop;
   logic [FW-1:0]     cur_floor;
   logic [FLOORS-1:0] pending;

   // Controller / environment side
   modport master (
      output call_btn, floor_tick, open, moving, error,
      input  close_req, open_req, up_req, down_req, stop, cur_floor, pending
   );

   // Dispatcher side
   modport slave (
      input  call_btn, floor_tick, open, moving, error,
      output close_req, open_req, up_req, down_req, stop, cur_floor, pending
   );
endinterface

// File: rtl/elevator_call_dispatcher.sv
// SCAN call dispatcher: latches floor calls, tracks the car floor from
// floor_tick pulses and sequences close/move/stop/open requests to the
// elevator controller. o_dbg_state exposes the FSM state.
module elevator_call_dispatcher #(
   parameter int FLOORS    = 8,
   parameter int FW        = 3,
   parameter int DOOR_HOLD = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   elevator_call_dispatcher_if.slave   bus,
   output logic [2:0]                  o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLOSE = 3'd1,
      S_MOVE  = 3'd2,
      S_STOP  = 3'd3,
      S_OPEN  = 3'd4,
      S_HOLD  = 3'd5,
      S_FAULT = 3'd6
   } state_t;

   localparam int HW = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(DOOR_HOLD - 1);
   localparam logic [FW-1:0] TOP_FLOOR = FW'(FLOORS - 1);

   state_t            r_state;
   logic              r_dir;        // 1 = up
   logic [FW-1:0]     r_cur_floor;
   logic [FLOORS-1:0] r_pending;
   logic [HW-1:0]     r_hold_cnt;
   logic              r_close_req;
   logic              r_open_req;
   logic              r_up_req;
   logic              r_down_req;
   logic              r_stop;

   state_t            w_state_next;
   logic              w_dir_next;
   logic [FW-1:0]     w_cur_floor_next;
   logic [HW-1:0]     w_hold_cnt_next;
   logic [FLOORS-1:0] w_clr;
   logic [FLOORS-1:0] w_pending_next;
   logic              w_above;
   logic              w_below;
   logic [FW-1:0]     w_step_floor;
   logic              w_at_end;

   // Calls at the car floor are absorbed while the doors are open.
   always_comb begin
      w_clr = '0;
      if (r_state == S_OPEN || r_state == S_HOLD)
         w_clr = {{(FLOORS-1){1'b0}}, 1'b1} << r_cur_floor;
      w_pending_next = (r_pending | bus.call_btn) & ~w_clr;
   end

   // Pending calls above / below the car, and the floor reached by the next tick.
   always_comb begin
      w_above = 1'b0;
      w_below = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (r_pending[i] && (FW'(i) > r_cur_floor)) w_above = 1'b1;
         if (r_pending[i] && (FW'(i) < r_cur_floor)) w_below = 1'b1;
      end
      if (r_dir)
         w_step_floor = (r_cur_floor == TOP_FLOOR) ? r_cur_floor : r_cur_floor + FW'(1);
      else
         w_step_floor = (r_cur_floor == '0) ? r_cur_floor : r_cur_floor - FW'(1);
      w_at_end = r_dir ? (w_step_floor == TOP_FLOOR) : (w_step_floor == '0);
   end

   // Next-state logic; error overrides every transition and freezes car state.
   always_comb begin
      w_state_next     = r_state;
      w_dir_next       = r_dir;
      w_cur_floor_next = r_cur_floor;
      w_hold_cnt_next  = r_hold_cnt;
      case (r_state)
         S_IDLE: begin
            if (r_pending[r_cur_floor]) begin
               w_state_next = S_OPEN;
            end else if (r_dir ? w_above : w_below) begin
               w_state_next = S_CLOSE;
            end else if (r_dir ? w_below : w_above) begin
               w_dir_next   = ~r_dir;
               w_state_next = S_CLOSE;
            end
         end
         S_CLOSE: if (!bus.open) w_state_next = S_MOVE;
         S_MOVE: begin
            if (bus.floor_tick) begin
               w_cur_floor_next = w_step_floor;
               if (w_pending_next[w_step_floor] || w_at_end) w_state_next = S_STOP;
            end
         end
         S_STOP: if (!bus.moving) w_state_next = S_OPEN;
         S_OPEN: begin
            if (bus.open) begin
               w_state_next    = S_HOLD;
               w_hold_cnt_next = HOLD_LOAD;
            end
         end
         S_HOLD: begin
            if (r_hold_cnt == '0)
               w_state_next = S_IDLE;
            else if (bus.call_btn[r_cur_floor])
               w_hold_cnt_next = HOLD_LOAD;
            else
               w_hold_cnt_next = r_hold_cnt - HW'(1);
         end
         S_FAULT: w_state_next = S_FAULT;
         default: w_state_next = S_IDLE;
      endcase
      if (bus.error) begin
         w_state_next     = S_FAULT;
         w_dir_next       = r_dir;
         w_cur_floor_next = r_cur_floor;
         w_hold_cnt_next  = r_hold_cnt;
      end
   end

   // State, car tracking and registered Moore request outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_dir       <= 1'b1;
         r_cur_floor <= '0;
         r_pending   <= '0;
         r_hold_cnt  <= '0;
         r_close_req <= 1'b0;
         r_open_req  <= 1'b0;
         r_up_req    <= 1'b0;
         r_down_req  <= 1'b0;
         r_stop      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_dir       <= w_dir_next;
         r_cur_floor <= w_cur_floor_next;
         r_pending   <= w_pending_next;
         r_hold_cnt  <= w_hold_cnt_next;
         r_close_req <= (w_state_next == S_CLOSE);
         r_open_req  <= (w_state_next == S_OPEN);
         r_up_req    <= (w_state_next == S_MOVE) &&  w_dir_next;
         r_down_req  <= (w_state_next == S_MOVE) && !w_dir_next;
         r_stop      <= (w_state_next == S_STOP) || (w_state_next == S_FAULT);
      end
   end

   assign bus.close_req = r_close_req;
   assign bus.open_req  = r_open_req;
   assign bus.up_req    = r_up_req;
   assign bus.down_req  = r_down_req;
   assign bus.stop      = r_stop;
   assign bus.cur_floor = r_cur_floor;
   assign bus.pending   = r_pending;
   assign o_dbg_state   = r_state;

endmodule
